// File: rtl/tone_detector.sv
// Square-wave period meter with optional C4/E4/G4 note classification.
// Note decoding is built only when TONE_DETECTOR_NOTE_DECODE_EN is defined; otherwise note is tied to 0.
module tone_detector #(
    parameter int unsigned clock_frequency   = 50000000,
    parameter int unsigned max_period_cycles = 1048575,
    parameter int unsigned tolerance_div     = 50
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        in,
    output logic [23:0] period,
    output logic        valid,
    output logic [1:0]  note,
    output logic        present
);

    localparam int DATA_W = 24;
    localparam logic [DATA_W-1:0] max_cnt = DATA_W'(max_period_cycles);

    localparam logic [0:0] IDLE    = 1'b0;
    localparam logic [0:0] MEASURE = 1'b1;

    logic              sync_p0;
    logic              sync_p1;
    logic              sync_p2;
    logic              edge_p3;
    logic [0:0]        state;
    logic [DATA_W-1:0] cnt;
    logic [DATA_W-1:0] cnt_inc;
    logic              timeout;

    // Stage p0-p2: metastability guard, then registered rising-edge detect (p3)
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            sync_p2 <= 1'b0;
            edge_p3 <= 1'b0;
        end else begin
            sync_p0 <= in;
            sync_p1 <= sync_p0;
            sync_p2 <= sync_p1;
            edge_p3 <= sync_p1 & ~sync_p2;
        end
    end

    assign cnt_inc = cnt + 1'b1;
    // A coincident edge takes priority over the timeout
    assign timeout = (state == MEASURE) && !edge_p3 && (cnt_inc == max_cnt);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            cnt     <= '0;
            period  <= '0;
            valid   <= 1'b0;
            present <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (state == IDLE) begin
                if (edge_p3) begin
                    cnt   <= '0;
                    state <= MEASURE;
                end
            end else if (edge_p3) begin
                period  <= cnt_inc;
                valid   <= 1'b1;
                present <= 1'b1;
                cnt     <= '0;
            end else if (timeout) begin
                state   <= IDLE;
                cnt     <= '0;
                period  <= '0;
                present <= 1'b0;
            end else begin
                cnt <= cnt_inc;
            end
        end
    end

`ifdef TONE_DETECTOR_NOTE_DECODE_EN
    localparam logic [63:0] freq_x100 = 64'(clock_frequency) * 64'd100;
    localparam logic [63:0] c4_p      = freq_x100 / 64'd26163;
    localparam logic [63:0] e4_p      = freq_x100 / 64'd32963;
    localparam logic [63:0] g4_p      = freq_x100 / 64'd39200;
    localparam logic [63:0] tol       = 64'(tolerance_div);

    localparam logic [DATA_W-1:0] c4_lo = DATA_W'(c4_p - c4_p / tol);
    localparam logic [DATA_W-1:0] c4_hi = DATA_W'(c4_p + c4_p / tol);
    localparam logic [DATA_W-1:0] e4_lo = DATA_W'(e4_p - e4_p / tol);
    localparam logic [DATA_W-1:0] e4_hi = DATA_W'(e4_p + e4_p / tol);
    localparam logic [DATA_W-1:0] g4_lo = DATA_W'(g4_p - g4_p / tol);
    localparam logic [DATA_W-1:0] g4_hi = DATA_W'(g4_p + g4_p / tol);

    function automatic logic [1:0] classify(input logic [DATA_W-1:0] p);
        if (p >= c4_lo && p <= c4_hi)      return 2'd1;
        else if (p >= e4_lo && p <= e4_hi) return 2'd2;
        else if (p >= g4_lo && p <= g4_hi) return 2'd3;
        else                               return 2'd0;
    endfunction

    logic [1:0] prev_class;
    logic       pair_armed;
    logic [1:0] cls;

    assign cls = classify(period);

    // Stage p4: debounce the class over two consecutive measurements
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            note       <= 2'd0;
            prev_class <= 2'd0;
            pair_armed <= 1'b0;
        end else if (timeout) begin
            note       <= 2'd0;
            pair_armed <= 1'b0;
        end else if (valid) begin
            if (pair_armed && (cls == prev_class))
                note <= cls;
            prev_class <= cls;
            pair_armed <= 1'b1;
        end
    end
`else
    assign note = 2'd0;

    // Frequency and tolerance only matter to the note decoder
    logic unused_cfg;
    assign unused_cfg = ^{32'(clock_frequency), 32'(tolerance_div)};
`endif

endmodule

// File: tb/tb_tone_detector.sv
// Directed bench for tone_detector: tone stimulus pushes expected measurements to a scoreboard,
// a monitor pops them on each valid pulse. Timing scaled down via clock_frequency/max_period_cycles.
module tb_tone_detector;

    localparam int unsigned CLK_HZ  = 500000;
    localparam int unsigned MAX_P   = 4000;
    localparam int unsigned TOL_DIV = 50;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        in;
    logic [23:0] period;
    logic        valid;
    logic [1:0]  note;
    logic        present;

    always #5 clock = ~clock;

    tone_detector #(
        .clock_frequency   (CLK_HZ),
        .max_period_cycles (MAX_P),
        .tolerance_div     (TOL_DIV)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .in      (in),
        .period  (period),
        .valid   (valid),
        .note    (note),
        .present (present)
    );

    int checks = 0;
    int passes = 0;

    // {expected note after this measurement, expected period}
    logic [25:0] sb[$];

    int         prev_len   = 0;
    bit         armed      = 0;
    logic [1:0] m_prev     = 2'd0;
    bit         m_have     = 0;
    logic [1:0] m_note     = 2'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // Windows at 500 kHz: C4 1911+/-38, E4 1516+/-30, G4 1275+/-25
    function automatic logic [1:0] model_class(input int p);
        if (p >= 1873 && p <= 1949)      return 2'd1;
        else if (p >= 1486 && p <= 1546) return 2'd2;
        else if (p >= 1250 && p <= 1300) return 2'd3;
        else                             return 2'd0;
    endfunction

    task automatic push_meas(input int p);
        logic [1:0] c;
        c = model_class(p);
`ifdef TONE_DETECTOR_NOTE_DECODE_EN
        if (m_have && c == m_prev) m_note = c;
`endif
        m_prev = c;
        m_have = 1;
        sb.push_back({m_note, 24'(p)});
    endtask

    task automatic model_clear();
        armed  = 0;
        m_have = 0;
        m_note = 2'd0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic tone(input int p, input int n);
        repeat (n) begin
            in = 1'b1;
            if (armed) push_meas(prev_len);
            armed = 1;
            wait_cycles(p / 2);
            in = 1'b0;
            wait_cycles(p - p / 2);
            prev_len = p;
        end
    endtask

    // Scoreboard consumer
    bit         note_pending = 0;
    logic [1:0] note_exp     = 2'd0;
    always @(negedge clock) begin
        if (reset_n === 1'b1) begin
            if (note_pending) begin
                chk("note_after_valid", 32'(note), 32'(note_exp));
                note_pending = 0;
            end
            if (valid === 1'b1) begin
                chk("valid_expected", 32'(sb.size() > 0), 32'd1);
                if (sb.size() > 0) begin
                    logic [25:0] e;
                    e = sb.pop_front();
                    chk("period", 32'(period), 32'(e[23:0]));
                    chk("present_on_valid", 32'(present), 32'd1);
                    note_exp     = e[25:24];
                    note_pending = 1;
                end
            end
        end
    end

    initial begin
        reset_n = 1'b0;
        in      = 1'b0;
        wait_cycles(4);
        chk("rst_period", 32'(period), 32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_note", 32'(note), 32'd0);
        chk("rst_present", 32'(present), 32'd0);
        reset_n = 1'b1;
        wait_cycles(3);

        // Note tracking across C4, window bounds, G4/E4 switching and a period equal to the timeout
        tone(1911, 3);
        tone(1873, 2);
        tone(1872, 2);
        tone(1949, 2);
        tone(1950, 2);
        tone(1911, 2);
        tone(1275, 1);
        tone(1516, 3);
        tone(MAX_P, 2);
        tone(1911, 2);

        // Hold low: timeout after MAX_P cycles from the last detected edge
        wait_cycles(MAX_P - 10 - 1911);
        chk("present_before_timeout", 32'(present), 32'd1);
        wait_cycles(30);
        chk("timeout_present", 32'(present), 32'd0);
        chk("timeout_note", 32'(note), 32'd0);
        chk("timeout_period", 32'(period), 32'd0);
        chk("timeout_valid", 32'(valid), 32'd0);
        model_clear();

        // Reset in the middle of a measurement
        tone(1911, 2);
        wait_cycles(500);
        reset_n = 1'b0;
        wait_cycles(5);
        chk("midrst_period", 32'(period), 32'd0);
        chk("midrst_note", 32'(note), 32'd0);
        chk("midrst_present", 32'(present), 32'd0);
        chk("midrst_valid", 32'(valid), 32'd0);
        reset_n = 1'b1;
        model_clear();
        wait_cycles(2);
        chk("post_rst_present", 32'(present), 32'd0);
        tone(1516, 3);
        wait_cycles(20);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        chk("final_present", 32'(present), 32'd1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
